impulse_convolver: RTL and testbench

IMPULSE_CONVOLVER -- requirements
Module: impulse_convolver

---
 rtl/convolver_pkg.sv | 32 +++
 rtl/impulse_convolver_if.sv | 24 ++
 rtl/sample_history_ram.sv | 36 +++
 rtl/impulse_convolver.sv | 180 ++++++++++++++++++
 tb/tb_impulse_convolver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/convolver_pkg.sv
// Shared state encoding, datapath widths and output saturation for the impulse convolver.
package convolver_pkg;

    localparam int unsigned ACC_WIDTH        = 48;
    localparam int unsigned SAMPLE_WIDTH     = 16;
    localparam int unsigned RAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // Clamp a wide signed value into the signed sample range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sample(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [ACC_WIDTH-1:0] lo;
        hi = ACC_WIDTH'(32767);
        lo = ACC_WIDTH'(-32768);
        if (v > hi) begin
            return hi[SAMPLE_WIDTH-1:0];
        end else if (v < lo) begin
            return lo[SAMPLE_WIDTH-1:0];
        end else begin
            return v[SAMPLE_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/impulse_convolver_if.sv
// Sample stream, impulse-memory read port and status signals of the convolver.
interface impulse_convolver_if;

    logic                                        sample_valid_in;
    logic signed [convolver_pkg::SAMPLE_WIDTH-1:0] sample_in;
    logic        [15:0]                          impulse_length;
    logic        [15:0]                          imp_read_addr;
    logic signed [convolver_pkg::SAMPLE_WIDTH-1:0] imp_read_data;
    logic signed [convolver_pkg::SAMPLE_WIDTH-1:0] sample_out;
    logic                                        sample_valid_out;
    logic                                        busy_out;
    logic                                        overrun_out;

    modport slave (
        input  sample_valid_in, sample_in, impulse_length, imp_read_data,
        output imp_read_addr, sample_out, sample_valid_out, busy_out, overrun_out
    );

    modport master (
        output sample_valid_in, sample_in, impulse_length, imp_read_data,
        input  imp_read_addr, sample_out, sample_valid_out, busy_out, overrun_out
    );

endinterface

// File: rtl/sample_history_ram.sv
// Dry-sample history: simple dual-port RAM with a two-stage registered read,
// aligned with the external impulse memory latency.
module sample_history_ram
    import convolver_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic signed [SAMPLE_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]                  rd_addr,
    output logic signed [SAMPLE_WIDTH-1:0] rd_data
);

    logic signed [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic        [AW-1:0]           rd_addr_q;
    logic signed [SAMPLE_WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Two-cycle read: address register then data register (no reset on storage path).
    always_ff @(posedge clk) begin
        rd_addr_q <= rd_addr;
        rd_data_q <= mem[rd_addr_q];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/impulse_convolver.sv
// Direct-form FIR convolution of the dry sample history against an external impulse
// memory; one tap per cycle, result saturated to 16 bits after a fixed right shift.
module impulse_convolver
    import convolver_pkg::*;
#(
    parameter int unsigned MAX_TAPS  = 4096,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                audio_clk,
    input  logic                rst_in_n,
    impulse_convolver_if.slave  bus
);

    localparam int unsigned AW = $clog2(MAX_TAPS);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = 2 * SAMPLE_WIDTH;

    conv_state_e                    state_q, state_d;
    logic [LW-1:0]                  k_q, k_d;
    logic [LW-1:0]                  len_q, len_d;
    logic [LW-1:0]                  fill_q, fill_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic                           busy_q, busy_d;
    logic                           overrun_q, overrun_d;
    logic signed [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                           valid_out_q, valid_out_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [PW-1:0]           prod_q, prod_d;
    logic [RAM_READ_LATENCY-1:0]    tap_m_q, tap_m_d;
    logic [RAM_READ_LATENCY-1:0]    tap_last_q, tap_last_d;
    logic                           prod_last_q, prod_last_d;

    logic                           issue, issue_last, ram_we, acc_clr;
    logic [LW-1:0]                  len_in;
    logic signed [SAMPLE_WIDTH-1:0] hist_data;

    sample_history_ram #(
        .DEPTH (MAX_TAPS),
        .AW    (AW)
    ) u_history (
        .clk     (audio_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.sample_in),
        .rd_addr (wr_ptr_q - k_q[AW-1:0]),
        .rd_data (hist_data)
    );

    // Requested tap count clamped to the history depth.
    always_comb begin
        if ({16'd0, bus.impulse_length} > MAX_TAPS) begin
            len_in = LW'(MAX_TAPS);
        end else begin
            len_in = LW'(bus.impulse_length);
        end
    end

    // Control FSM: accept, issue taps, wait for the pipeline to empty, publish.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        len_d        = len_q;
        fill_d       = fill_q;
        wr_ptr_d     = wr_ptr_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        sample_out_d = sample_out_q;
        valid_out_d  = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        ram_we       = 1'b0;
        acc_clr      = 1'b0;

        if (bus.sample_valid_in && busy_q) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.sample_valid_in) begin
                    ram_we  = 1'b1;
                    acc_clr = 1'b1;
                    k_d     = '0;
                    len_d   = len_in;
                    if (fill_q != LW'(MAX_TAPS)) begin
                        fill_d = fill_q + LW'(1);
                    end
                    // Zero-length impulse: publish silence at once, no tap loop.
                    if (len_in == '0) begin
                        sample_out_d = '0;
                        valid_out_d  = 1'b1;
                        wr_ptr_d     = wr_ptr_q + AW'(1);
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                issue = 1'b1;
                k_d   = k_q + LW'(1);
                if (k_q == len_q - LW'(1)) begin
                    issue_last = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (prod_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sample_out_d = sat_sample(acc_q >>> OUT_SHIFT);
                valid_out_d  = 1'b1;
                wr_ptr_d     = wr_ptr_q + AW'(1);
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: tap mask/last flags ride alongside the memory reads, then multiply and accumulate.
    always_comb begin
        tap_m_d     = {tap_m_q[RAM_READ_LATENCY-2:0], issue && (k_q < fill_q)};
        tap_last_d  = {tap_last_q[RAM_READ_LATENCY-2:0], issue_last};
        prod_last_d = tap_last_q[RAM_READ_LATENCY-1];
        prod_d      = '0;
        if (tap_m_q[RAM_READ_LATENCY-1]) begin
            prod_d = PW'(hist_data) * PW'(bus.imp_read_data);
        end
        if (acc_clr) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q + {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
        end
    end

    // State and datapath registers.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            len_q        <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sample_out_q <= '0;
            valid_out_q  <= 1'b0;
            acc_q        <= '0;
            prod_q       <= '0;
            tap_m_q      <= '0;
            tap_last_q   <= '0;
            prod_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            sample_out_q <= sample_out_d;
            valid_out_q  <= valid_out_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            tap_m_q      <= tap_m_d;
            tap_last_q   <= tap_last_d;
            prod_last_q  <= prod_last_d;
        end
    end

    assign bus.imp_read_addr    = (state_q == RUN) ? 16'(k_q) : '0;
    assign bus.sample_out       = sample_out_q;
    assign bus.sample_valid_out = valid_out_q;
    assign bus.busy_out         = busy_q;
    assign bus.overrun_out      = overrun_q;

endmodule

// File: tb/tb_impulse_convolver.sv
// Directed bench for impulse_convolver with a two-cycle impulse memory model.
module tb_impulse_convolver;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic signed [15:0] coef [4096];
    logic        [15:0] ra1;

    impulse_convolver_if bus ();

    impulse_convolver #(
        .MAX_TAPS  (4096),
        .OUT_SHIFT (15)
    ) dut (
        .audio_clk (clk),
        .rst_in_n  (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Impulse memory: data valid two cycles after the address.
    always @(posedge clk) begin
        ra1               <= bus.imp_read_addr;
        bus.imp_read_data <= coef[ra1[11:0]];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clr_coef();
        for (int i = 0; i < 4096; i++) coef[i] = '0;
    endtask

    // Send one sample; optionally inject another valid at cycle inj_cyc (0 = none).
    // impulse_length is disturbed at cycle 1 to show the latched length is used.
    task automatic run_sample(input logic signed [15:0] s, input logic [15:0] len,
                              input int inj_cyc, input logic signed [15:0] inj_s,
                              output int cyc, output logic signed [15:0] val,
                              output logic [15:0] addr3, output logic busy1);
        bit got;
        got   = 1'b0;
        cyc   = 0;
        val   = '0;
        addr3 = '0;
        busy1 = 1'b0;
        @(negedge clk);
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = s;
        bus.impulse_length  = len;
        for (int i = 1; i <= 5000 && !got; i++) begin
            @(negedge clk);
            if (i == inj_cyc) begin
                bus.sample_valid_in = 1'b1;
                bus.sample_in       = inj_s;
            end else begin
                bus.sample_valid_in = 1'b0;
            end
            if (i == 1) begin
                busy1              = bus.busy_out;
                bus.impulse_length = 16'd1;
            end
            if (i == 3) addr3 = bus.imp_read_addr;
            if (bus.sample_valid_out) begin
                got = 1'b1;
                cyc = i;
                val = bus.sample_out;
            end
        end
        if (!got) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 cyc;
        int                 vcount;
        logic signed [15:0] val;
        logic        [15:0] a3;
        logic               b1;

        rst_n               = 1'b0;
        bus.sample_valid_in = 1'b0;
        bus.sample_in       = '0;
        bus.impulse_length  = '0;
        clr_coef();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sample_out", bus.sample_out, 0);
        chk("rst_valid_out", bus.sample_valid_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_overrun", bus.overrun_out, 0);
        chk("rst_addr", bus.imp_read_addr, 0);
        rst_n = 1'b1;

        // Unit-ish impulse, L=4
        coef[0] = 16'sd16384;
        run_sample(16'sd1000, 16'd4, 0, '0, cyc, val, a3, b1);
        chk("l4_out1", val, 500);
        chk("l4_lat1", cyc, 9);
        chk("l4_addr_c3", a3, 2);
        chk("l4_busy_c1", b1, 1);
        run_sample(-16'sd2000, 16'd4, 0, '0, cyc, val, a3, b1);
        chk("l4_out2", val, -1000);
        chk("l4_lat2", cyc, 9);
        repeat (3) @(negedge clk);
        chk("hold_sample_out", bus.sample_out, -1000);
        chk("hold_valid_low", bus.sample_valid_out, 0);
        chk("idle_addr_zero", bus.imp_read_addr, 0);
        chk("idle_busy_low", bus.busy_out, 0);

        // Fill-count masking, L=2
        do_reset();
        clr_coef();
        coef[0] = 16'sd32767;
        coef[1] = 16'sd32767;
        run_sample(16'sd100, 16'd2, 0, '0, cyc, val, a3, b1);
        chk("mask_out1", val, 99);
        chk("mask_lat1", cyc, 7);
        run_sample(16'sd100, 16'd2, 0, '0, cyc, val, a3, b1);
        chk("mask_out2", val, 199);

        // Saturation, L=3
        do_reset();
        coef[2] = 16'sd32767;
        run_sample(16'sd32767, 16'd3, 0, '0, cyc, val, a3, b1);
        chk("satp_out1", val, 32766);
        run_sample(16'sd32767, 16'd3, 0, '0, cyc, val, a3, b1);
        chk("satp_out2", val, 32767);
        run_sample(16'sd32767, 16'd3, 0, '0, cyc, val, a3, b1);
        chk("satp_out3", val, 32767);
        do_reset();
        run_sample(-16'sd32768, 16'd3, 0, '0, cyc, val, a3, b1);
        chk("satn_out1", val, -32767);
        run_sample(-16'sd32768, 16'd3, 0, '0, cyc, val, a3, b1);
        run_sample(-16'sd32768, 16'd3, 0, '0, cyc, val, a3, b1);
        chk("satn_out3", val, -32768);

        // Overrun while busy, L=8
        do_reset();
        clr_coef();
        coef[0] = 16'sd8192;  coef[1] = 16'sd4096;  coef[2] = -16'sd4096; coef[3] = 16'sd2048;
        coef[4] = 16'sd1024;  coef[5] = 16'sd512;   coef[6] = 16'sd256;   coef[7] = 16'sd128;
        run_sample(16'sd1000, 16'd8, 0, '0, cyc, val, a3, b1);
        chk("ovr_out1", val, 250);
        chk("ovr_clear_before", bus.overrun_out, 0);
        run_sample(16'sd2000, 16'd8, 2, 16'sd30000, cyc, val, a3, b1);
        chk("ovr_out2", val, 625);
        chk("ovr_lat2", cyc, 13);
        chk("ovr_set", bus.overrun_out, 1);
        run_sample(-16'sd3000, 16'd8, 0, '0, cyc, val, a3, b1);
        chk("ovr_out3", val, -625);
        chk("ovr_sticky", bus.overrun_out, 1);

        // Reset mid-run, L=16
        clr_coef();
        coef[0] = 16'sd16384;
        coef[1] = 16'sd16384;
        @(negedge clk);
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = 16'sd9000;
        bus.impulse_length  = 16'd16;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.sample_valid_in = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_sample_out", bus.sample_out, 0);
        chk("abort_valid", bus.sample_valid_out, 0);
        chk("abort_busy", bus.busy_out, 0);
        chk("abort_overrun", bus.overrun_out, 0);
        chk("abort_addr", bus.imp_read_addr, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.sample_valid_out) vcount++;
        end
        chk("abort_no_strobe", vcount, 0);
        run_sample(16'sd600, 16'd16, 0, '0, cyc, val, a3, b1);
        chk("abort_next_out", val, 300);
        chk("abort_next_lat", cyc, 21);

        // Zero length and clamped length
        do_reset();
        clr_coef();
        coef[0] = 16'sd16384;
        coef[1] = 16'sd8192;
        run_sample(16'sd5000, 16'd0, 0, '0, cyc, val, a3, b1);
        chk("l0_out", val, 0);
        chk("l0_lat", cyc, 1);
        chk("l0_busy_c1", b1, 0);
        run_sample(16'sd4000, 16'd65535, 0, '0, cyc, val, a3, b1);
        chk("lmax_out", val, 3250);
        chk("lmax_lat", cyc, 4101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
